wb_req_master: RTL and testbench

- Wishbone B4 classic single-cycle master that drives the Wishbone slave port of the SDRAM controller.
- Converts a valid/ready request stream from the traffic source into Wishbone cycles, one outstanding cycle at a time.
- Holds off all traffic until SDRAM initialisation completes.
- Returns read data or a timeout error on a valid/ready response stream.

---
 rtl/wb_req_master.sv | 137 +++++++++++++
 tb/tb_wb_req_master.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_req_master.sv
// Wishbone B4 classic master: one outstanding single cycle at a time, gated by
// SDRAM init, with an ack timeout reported as an error response.
module wb_req_master #(
   parameter int unsigned AW          = 26,
   parameter int unsigned DW          = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            sdr_init_done,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_sel,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_err,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   output logic            spurious_ack
);
   localparam int unsigned   SW       = DW / 8;
   localparam int unsigned   CW       = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {WAIT_INIT, IDLE, BUS, RESP} state_t;

   state_t          state, state_nxt;
   logic            init_meta, init_sync;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            cyc_nxt, we_nxt, rsp_valid_nxt, rsp_err_nxt, spur_nxt;
   logic [AW-1:0]   adr_nxt;
   logic [DW-1:0]   dat_nxt, rdata_nxt;
   logic [SW-1:0]   sel_nxt;

   assign wb_stb_o  = wb_cyc_o;
   assign req_ready = (state == IDLE) && init_sync;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= WAIT_INIT;
         init_meta    <= 1'b0;
         init_sync    <= 1'b0;
         cnt          <= '0;
         wb_cyc_o     <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_adr_o     <= '0;
         wb_dat_o     <= '0;
         wb_sel_o     <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         spurious_ack <= 1'b0;
      end else begin
         state        <= state_nxt;
         init_meta    <= sdr_init_done;
         init_sync    <= init_meta;
         cnt          <= cnt_nxt;
         wb_cyc_o     <= cyc_nxt;
         wb_we_o      <= we_nxt;
         wb_adr_o     <= adr_nxt;
         wb_dat_o     <= dat_nxt;
         wb_sel_o     <= sel_nxt;
         rsp_valid    <= rsp_valid_nxt;
         rsp_rdata    <= rdata_nxt;
         rsp_err      <= rsp_err_nxt;
         spurious_ack <= spur_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cyc_nxt       = wb_cyc_o;
      we_nxt        = wb_we_o;
      adr_nxt       = wb_adr_o;
      dat_nxt       = wb_dat_o;
      sel_nxt       = wb_sel_o;
      rsp_valid_nxt = rsp_valid;
      rdata_nxt     = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      spur_nxt      = wb_ack_i && (state != BUS);

      unique case (state)
         WAIT_INIT: begin
            if (init_sync) state_nxt = IDLE;
         end
         IDLE: begin
            if (!init_sync) begin
               state_nxt = WAIT_INIT;
            end else if (req_valid) begin
               we_nxt    = req_we;
               adr_nxt   = req_addr;
               dat_nxt   = req_wdata;
               sel_nxt   = req_sel;
               cyc_nxt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = BUS;
            end
         end
         BUS: begin
            // ack is tested first so it wins over a coincident timeout
            if (wb_ack_i) begin
               cyc_nxt       = 1'b0;
               rdata_nxt     = wb_we_o ? '0 : wb_dat_i;
               rsp_err_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else if (cnt == CNT_LAST) begin
               cyc_nxt       = 1'b0;
               rdata_nxt     = '0;
               rsp_err_nxt   = 1'b1;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = init_sync ? IDLE : WAIT_INIT;
            end
         end
         default: state_nxt = WAIT_INIT;
      endcase
   end
endmodule

// File: tb/tb_wb_req_master.sv
// Self-checking bench for wb_req_master: memory-backed Wishbone slave with
// programmable ack latency and a transaction-level response model.
module tb_wb_req_master;
   localparam int unsigned AW = 26;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          sdr_init_done = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [3:0]    req_sel = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic [DW-1:0] wb_dat_i = '0;
   logic          wb_ack_i, spurious_ack;
   logic          slave_ack = 1'b0, force_ack = 1'b0;

   int checks = 0;
   int failures = 0;

   assign wb_ack_i = slave_ack | force_ack;
   always #5 wb_clk_i = ~wb_clk_i;

   wb_req_master #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .sdr_init_done(sdr_init_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .spurious_ack(spurious_ack)
   );

   // ---------------- slave / bus monitor ----------------
   int            cycle = 0;
   int            slave_wait = 1000;
   int            cyc_cnt = 0;
   int            stb_bad = 0;
   int            cyc_lens[$];
   int            cyc_starts[$];
   logic          mon_we;
   logic [AW-1:0] mon_adr;
   logic [DW-1:0] mon_dat;
   logic [3:0]    mon_sel;
   bit            mon_unstable = 0;
   logic [DW-1:0] mem [int];
   logic [DW-1:0] ref_mem [int];

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [3:0] sel);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] slave_read(input logic [AW-1:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : dflt(a);
   endfunction

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
   endfunction

   always @(posedge wb_clk_i) begin
      cycle++;
      #1;
      if (wb_stb_o !== wb_cyc_o) stb_bad++;
      if (wb_cyc_o === 1'b1) begin
         if (cyc_cnt == 0) begin
            mon_we = wb_we_o; mon_adr = wb_adr_o; mon_dat = wb_dat_o; mon_sel = wb_sel_o;
            mon_unstable = 0;
            cyc_starts.push_back(cycle);
         end else if (wb_we_o !== mon_we || wb_adr_o !== mon_adr ||
                      wb_dat_o !== mon_dat || wb_sel_o !== mon_sel) begin
            mon_unstable = 1;
         end
         cyc_cnt++;
         wb_dat_i  = slave_read(wb_adr_o);
         slave_ack = (cyc_cnt == slave_wait + 1);
         if (slave_ack && wb_we_o) mem[int'(wb_adr_o)] = merge(slave_read(wb_adr_o), wb_dat_o, wb_sel_o);
      end else begin
         if (cyc_cnt != 0) cyc_lens.push_back(cyc_cnt);
         cyc_cnt   = 0;
         slave_ack = 1'b0;
         wb_dat_i  = '0;
      end
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge wb_clk_i);
      #2;
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] sel, input int wt, output int len, output logic got,
                        output logic [DW-1:0] rd, output logic er);
      int n;
      int base;
      base = cyc_lens.size();
      slave_wait = wt;
      rsp_ready = 1'b0;
      req_we = we; req_addr = addr; req_wdata = wd; req_sel = sel; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) begin
         checks++; failures++;
         $display("FAIL issue_wait_ready req_ready=%b required=1 within 50 cycles", req_ready);
      end
      step();
      req_valid = 1'b0;
      n = 0;
      while (wb_cyc_o === 1'b1 && n < 200) begin step(); n++; end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL issue_cyc_end cyc=%b required=0 within 200 cycles", wb_cyc_o);
      end
      len = (cyc_lens.size() > base) ? cyc_lens[$] : 0;
      got = rsp_valid; rd = rsp_rdata; er = rsp_err;
   endtask

   task automatic release_rsp(input int hold, output logic held_ok);
      logic [DW-1:0] rd;
      logic er;
      rd = rsp_rdata; er = rsp_err; held_ok = 1'b1;
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er) held_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({req_ready, rsp_valid, rsp_rdata, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o,
              wb_adr_o, wb_dat_o, wb_sel_o, spurious_ack} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cycle=%0d cyc=%b rsp_valid=%b req_ready=%b required all 0",
                     cycle, wb_cyc_o, rsp_valid, req_ready);
         end
      end
      wb_rst_i = 1'b0;
      while (cycle < 19) begin
         step();
         checks++;
         if (req_ready !== 1'b0 || wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL pre_init cycle=%0d req_ready=%b stb=%b required 0/0", cycle, req_ready, wb_stb_o);
         end
      end
      sdr_init_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (req_ready !== (cycle >= 22) || wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL init_sync cycle=%0d req_ready=%b required=%b stb=%b", cycle, req_ready,
                     cycle >= 22, wb_stb_o);
         end
      end
   endtask

   task automatic test_write();
      int len; logic got, er, h; logic [DW-1:0] rd;
      issue(1'b1, 26'h10, 32'hDEADBEEF, 4'hF, 3, len, got, rd, er);
      ref_mem[16] = merge(ref_read(26'h10), 32'hDEADBEEF, 4'hF);
      checks++;
      if (len !== 4) begin failures++; $display("FAIL write_cyc_len got=%0d required=4", len); end
      checks++;
      if ({mon_we, mon_adr, mon_dat, mon_sel} !== {1'b1, 26'h10, 32'hDEADBEEF, 4'hF} || mon_unstable) begin
         failures++;
         $display("FAIL write_bus we=%b adr=%h dat=%h sel=%h unstable=%0d required 1/10/deadbeef/f/0",
                  mon_we, mon_adr, mon_dat, mon_sel, mon_unstable);
      end
      checks++;
      if ({got, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL write_rsp valid=%b err=%b rdata=%h required 1/0/0", got, er, rd);
      end
      release_rsp(0, h);
   endtask

   task automatic test_read_hold();
      int len; logic got, er, h; logic [DW-1:0] rd;
      issue(1'b0, 26'h10, 32'h0, 4'hF, 0, len, got, rd, er);
      checks++;
      if ({got, er, rd} !== {1'b1, 1'b0, 32'hDEADBEEF} || len !== 1) begin
         failures++;
         $display("FAIL read_rsp valid=%b err=%b rdata=%h len=%0d required 1/0/deadbeef/1", got, er, rd, len);
      end
      release_rsp(4, h);
      checks++;
      if (h !== 1'b1) begin failures++; $display("FAIL read_hold held=%b required=1", h); end
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL read_release rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_timeout();
      int len; logic got, er, h; logic [DW-1:0] rd;
      issue(1'b0, 26'h20, 32'h0, 4'hF, 1000, len, got, rd, er);
      checks++;
      if (len !== TO || {got, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL timeout_rsp len=%0d valid=%b err=%b rdata=%h required %0d/1/1/0", len, got, er, rd, TO);
      end
      step();
      checks++;
      if (spurious_ack !== 1'b0) begin failures++; $display("FAIL spur_idle got=%b required=0", spurious_ack); end
      force_ack = 1'b1;
      step();
      force_ack = 1'b0;
      checks++;
      if (spurious_ack !== 1'b1) begin failures++; $display("FAIL spur_pulse got=%b required=1", spurious_ack); end
      step();
      checks++;
      if (spurious_ack !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
         failures++;
         $display("FAIL spur_after spur=%b rsp_valid=%b err=%b required 0/1/1", spurious_ack, rsp_valid, rsp_err);
      end
      release_rsp(0, h);
   endtask

   task automatic test_reset_mid_bus();
      int n; bit saw_rsp; int len; logic got, er, h; logic [DW-1:0] rd;
      slave_wait = 1000;
      req_we = 1'b0; req_addr = 26'h3; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
      step();
      req_valid = 1'b0;
      step();
      wb_rst_i = 1'b1;
      step();
      checks++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid, req_ready} !== 4'b0000) begin
         failures++;
         $display("FAIL rst_mid cyc=%b stb=%b rsp_valid=%b req_ready=%b required 0000",
                  wb_cyc_o, wb_stb_o, rsp_valid, req_ready);
      end
      wb_rst_i = 1'b0;
      n = 0; saw_rsp = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         step(); n++;
         if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) saw_rsp = 1;
      end
      checks++;
      if (n !== 3 || saw_rsp) begin
         failures++;
         $display("FAIL rst_resume cycles=%0d required=3 stray_activity=%0d required=0", n, saw_rsp);
      end
      issue(1'b1, 26'h5, 32'h12345678, 4'h3, 1, len, got, rd, er);
      ref_mem[5] = merge(ref_read(26'h5), 32'h12345678, 4'h3);
      checks++;
      if (len !== 2 || {got, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL rst_after_txn len=%0d valid=%b err=%b rdata=%h required 2/1/0/0", len, got, er, rd);
      end
      release_rsp(0, h);
   endtask

   task automatic test_init_drop();
      int n; int len; logic got, er, h; logic [DW-1:0] rd;
      issue(1'b0, 26'h5, 32'h0, 4'hF, 1, len, got, rd, er);
      sdr_init_done = 1'b0;
      release_rsp(4, h);
      checks++;
      if (h !== 1'b1 || rd !== ref_read(26'h5) || er !== 1'b0) begin
         failures++;
         $display("FAIL init_drop_rsp held=%b rdata=%h required 1/%h", h, rd, ref_read(26'h5));
      end
      n = 0;
      for (int i = 0; i < 3; i++) begin
         if (req_ready !== 1'b0) n++;
         step();
      end
      checks++;
      if (n !== 0) begin failures++; $display("FAIL init_drop_ready cycles_ready=%0d required=0", n); end
      sdr_init_done = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (n !== 3) begin failures++; $display("FAIL init_regain cycles=%0d required=3", n); end
   endtask

   task automatic test_random();
      int tw[4] = '{15, 16, 0, 14};
      int len, wt, hold, exp_len;
      logic got, er, h, we, exp_err;
      logic [AW-1:0] a;
      logic [DW-1:0] rd, wd, exp_rd;
      logic [3:0] sel;
      for (int i = 0; i < 24; i++) begin
         wt   = (i < 4) ? tw[i] : int'($urandom_range(0, 20));
         we   = 1'($urandom_range(0, 1));
         a    = AW'($urandom_range(0, 7));
         wd   = $urandom;
         sel  = 4'($urandom_range(0, 15));
         hold = int'($urandom_range(0, 3));
         exp_err = (wt >= TO);
         exp_len = exp_err ? TO : wt + 1;
         exp_rd  = (exp_err || we) ? '0 : ref_read(a);
         if (!exp_err && we) ref_mem[int'(a)] = merge(ref_read(a), wd, sel);
         issue(we, a, wd, sel, wt, len, got, rd, er);
         checks++;
         if (len !== exp_len) begin
            failures++; $display("FAIL rand_len i=%0d wait=%0d got=%0d required=%0d", i, wt, len, exp_len);
         end
         checks++;
         if ({mon_we, mon_adr, mon_dat, mon_sel} !== {we, a, wd, sel} || mon_unstable) begin
            failures++;
            $display("FAIL rand_bus i=%0d we=%b adr=%h dat=%h sel=%h unstable=%0d required %b/%h/%h/%h/0",
                     i, mon_we, mon_adr, mon_dat, mon_sel, mon_unstable, we, a, wd, sel);
         end
         checks++;
         if ({got, er, rd} !== {1'b1, exp_err, exp_rd}) begin
            failures++;
            $display("FAIL rand_rsp i=%0d valid=%b err=%b rdata=%h required 1/%b/%h", i, got, er, rd, exp_err, exp_rd);
         end
         release_rsp(hold, h);
         checks++;
         if (h !== 1'b1) begin failures++; $display("FAIL rand_hold i=%0d held=%b required=1", i, h); end
      end
   endtask

   task automatic test_back_to_back();
      logic          bw[8];
      logic [AW-1:0] ba[8];
      logic [DW-1:0] bd[8], be[8];
      logic [3:0]    bs[8];
      int idx, got, base, n;
      bit hs;
      for (int i = 0; i < 8; i++) begin
         bw[i] = 1'($urandom_range(0, 1));
         ba[i] = AW'($urandom_range(0, 7));
         bd[i] = $urandom;
         bs[i] = 4'($urandom_range(0, 15));
         be[i] = bw[i] ? '0 : ref_read(ba[i]);
         if (bw[i]) ref_mem[int'(ba[i])] = merge(ref_read(ba[i]), bd[i], bs[i]);
      end
      base = cyc_starts.size();
      slave_wait = 0;
      rsp_ready = 1'b1;
      idx = 0; got = 0;
      req_we = bw[0]; req_addr = ba[0]; req_wdata = bd[0]; req_sel = bs[0]; req_valid = 1'b1;
      for (n = 0; n < 60 && got < 8; n++) begin
         hs = req_valid && req_ready;
         step();
         if (rsp_valid === 1'b1) begin
            checks++;
            if (rsp_rdata !== be[got] || rsp_err !== 1'b0) begin
               failures++;
               $display("FAIL b2b_rsp n=%0d rdata=%h err=%b required %h/0", got, rsp_rdata, rsp_err, be[got]);
            end
            got++;
         end
         if (hs) begin
            idx++;
            if (idx < 8) begin
               req_we = bw[idx]; req_addr = ba[idx]; req_wdata = bd[idx]; req_sel = bs[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      checks++;
      if (got !== 8 || cyc_starts.size() - base !== 8) begin
         failures++;
         $display("FAIL b2b_count responses=%0d cycles=%0d required 8/8", got, cyc_starts.size() - base);
      end else begin
         for (int i = base + 1; i < base + 8; i++) begin
            checks++;
            if (cyc_starts[i] - cyc_starts[i-1] !== 3) begin
               failures++;
               $display("FAIL b2b_spacing i=%0d spacing=%0d required=3", i - base, cyc_starts[i] - cyc_starts[i-1]);
            end
         end
         checks++;
         if (cyc_lens[$] !== 1) begin failures++; $display("FAIL b2b_len got=%0d required=1", cyc_lens[$]); end
      end
   endtask

   task automatic test_stb_cyc();
      checks++;
      if (stb_bad !== 0) begin failures++; $display("FAIL stb_eq_cyc mismatched_cycles=%0d required=0", stb_bad); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_hold();
      test_timeout();
      test_reset_mid_bus();
      test_init_drop();
      test_random();
      test_back_to_back();
      test_stb_cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
